// File: rtl/bench_bfm_ctrl.sv
// rtl/bench_bfm_ctrl.sv - multi-agent BFM activity controller with staggered release, drain and per-channel counters
// Optional feature macro: BENCH_BFM_CTRL_TXN_VIEW_EN (per-channel transaction-viewing mask)
module bench_bfm_ctrl #(
  parameter int NUM_AGENTS = 4,
  parameter int CNT_W      = 16,
  parameter int STAGGER    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_wr,
  input  logic                        cfg_sel,
  input  logic [NUM_AGENTS-1:0]       cfg_wdata,
  input  logic                        cmd_start,
  input  logic                        cmd_stop,
  input  logic                        cmd_clr,
  input  logic [NUM_AGENTS-1:0]       txn_in,
  output logic [NUM_AGENTS-1:0]       bfm_en,
  output logic [NUM_AGENTS-1:0]       txn_view,
  output logic [NUM_AGENTS*CNT_W-1:0] txn_cnt,
  output logic [1:0]                  state,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Countdown reload: a value of STAGGER-1 gives exactly STAGGER cycles per step
  localparam logic [7:0] STG_RELOAD = 8'(STAGGER - 1);

  state_t                  state_q, state_d;
  logic [NUM_AGENTS-1:0]   en_mask_q, en_mask_d;
  logic [NUM_AGENTS-1:0]   bfm_en_q, bfm_en_d;
  logic [7:0]              stg_q, stg_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        cnt_q [NUM_AGENTS];
  logic [CNT_W-1:0]        cnt_d [NUM_AGENTS];

  // Enabled channels not yet released; next_bit isolates the lowest of them
  logic [NUM_AGENTS-1:0]   pending;
  logic [NUM_AGENTS-1:0]   next_bit;

  assign pending  = en_mask_q & ~bfm_en_q;
  assign next_bit = pending & (~pending + NUM_AGENTS'(1));

  // Control FSM next-state: mask capture, staggered release, drain countdown
  always_comb begin
    state_d   = state_q;
    en_mask_d = en_mask_q;
    bfm_en_d  = bfm_en_q;
    stg_d     = stg_q;
    done_d    = 1'b0;

    if (cfg_wr && !cfg_sel && (state_q == ST_IDLE)) begin
      en_mask_d = cfg_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        bfm_en_d = '0;
        // In IDLE bfm_en_q is zero, so next_bit is the lowest enabled channel
        if (cmd_start && !cmd_stop && (en_mask_q != '0)) begin
          state_d  = ST_RELEASE;
          bfm_en_d = next_bit;
          stg_d    = STG_RELOAD;
        end
      end
      ST_RELEASE: begin
        if (cmd_stop) begin
          state_d  = ST_DRAIN;
          bfm_en_d = '0;
          stg_d    = STG_RELOAD;
        end else if (bfm_en_q == en_mask_q) begin
          state_d = ST_ACTIVE;
        end else if (stg_q == 8'd0) begin
          bfm_en_d = bfm_en_q | next_bit;
          stg_d    = STG_RELOAD;
        end else begin
          stg_d = stg_q - 8'd1;
        end
      end
      ST_ACTIVE: begin
        bfm_en_d = en_mask_q;
        if (cmd_stop) begin
          state_d  = ST_DRAIN;
          bfm_en_d = '0;
          stg_d    = STG_RELOAD;
        end
      end
      default: begin
        bfm_en_d = '0;
        if (stg_q == 8'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          stg_d = stg_q - 8'd1;
        end
      end
    endcase
  end

  // Control FSM state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      en_mask_q <= '0;
      bfm_en_q  <= '0;
      stg_q     <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_mask_q <= en_mask_d;
      bfm_en_q  <= bfm_en_d;
      stg_q     <= stg_d;
      done_q    <= done_d;
    end
  end

  // Per-channel saturating counters; clear dominates a coincident increment
  always_comb begin
    for (int i = 0; i < NUM_AGENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cmd_clr) begin
        cnt_d[i] = '0;
      end else if (txn_in[i] && bfm_en_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AGENTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_AGENTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_AGENTS; g++) begin : g_pack
    assign txn_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

`ifdef BENCH_BFM_CTRL_TXN_VIEW_EN
  logic [NUM_AGENTS-1:0] view_mask_q, view_mask_d;
  logic [NUM_AGENTS-1:0] txn_view_q, txn_view_d;

  // View mask is writable in any state; txn_view tracks bfm_en in the same cycle
  always_comb begin
    view_mask_d = view_mask_q;
    if (cfg_wr && cfg_sel) begin
      view_mask_d = cfg_wdata;
    end
    txn_view_d = view_mask_d & bfm_en_d;
  end

  // View mask and gated view output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      view_mask_q <= '0;
      txn_view_q  <= '0;
    end else begin
      view_mask_q <= view_mask_d;
      txn_view_q  <= txn_view_d;
    end
  end

  assign txn_view = txn_view_q;
`else
  assign txn_view = '0;
`endif

  assign bfm_en = bfm_en_q;
  assign state  = state_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_bench_bfm_ctrl.sv
// tb/tb_bench_bfm_ctrl.sv - directed self-checking bench for bench_bfm_ctrl
module tb_bench_bfm_ctrl;

  localparam int NA = 4;
  localparam int CW = 4;
  localparam int ST = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_wr = 1'b0;
  logic              cfg_sel = 1'b0;
  logic [NA-1:0]     cfg_wdata = '0;
  logic              cmd_start = 1'b0;
  logic              cmd_stop = 1'b0;
  logic              cmd_clr = 1'b0;
  logic [NA-1:0]     txn_in = '0;
  logic [NA-1:0]     bfm_en;
  logic [NA-1:0]     txn_view;
  logic [NA*CW-1:0]  txn_cnt;
  logic [1:0]        state;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;

  bench_bfm_ctrl #(.NUM_AGENTS(NA), .CNT_W(CW), .STAGGER(ST)) dut (
    .clock(clock), .reset(reset), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_clr(cmd_clr), .txn_in(txn_in), .bfm_en(bfm_en), .txn_view(txn_view),
    .txn_cnt(txn_cnt), .state(state), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic write_cfg(input logic sel, input logic [NA-1:0] d);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_wdata = d;
    tick(1);
    cfg_wr = 1'b0; cfg_sel = 1'b0; cfg_wdata = '0;
  endtask

  // Returns after the start edge T, i.e. observing the T+1 values
  task automatic start();
    cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0;
  endtask

  task automatic stop();
    cmd_stop = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    tests++; if (state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_ctrl got state=%0d busy=%b done=%b exp 0 0 0", state, busy, done); end
    tests++; if (bfm_en !== 4'b0000 || txn_view !== 4'b0000) begin fails++; $display("FAIL rst_en got bfm_en=%b txn_view=%b exp 0000 0000", bfm_en, txn_view); end
    tests++; if (txn_cnt !== 16'h0000) begin fails++; $display("FAIL rst_cnt got=%h exp=0000", txn_cnt); end
    reset = 1'b1;
    tick(1);
    tests++; if (state !== 2'd0 || bfm_en !== 4'b0000) begin fails++; $display("FAIL rst_release got state=%0d bfm_en=%b exp 0 0000", state, bfm_en); end
  endtask

  task automatic test_release();
    write_cfg(1'b0, 4'b1011);
    start();
    tests++; if (bfm_en !== 4'b0001 || state !== 2'd1 || busy !== 1'b1) begin fails++; $display("FAIL rel_t1 got bfm_en=%b state=%0d busy=%b exp 0001 1 1", bfm_en, state, busy); end
    tick(3);
    tests++; if (bfm_en !== 4'b0001) begin fails++; $display("FAIL rel_t4 got=%b exp=0001", bfm_en); end
    tick(1);
    tests++; if (bfm_en !== 4'b0011) begin fails++; $display("FAIL rel_t5 got=%b exp=0011", bfm_en); end
    tick(3);
    tests++; if (bfm_en !== 4'b0011) begin fails++; $display("FAIL rel_t8 got=%b exp=0011", bfm_en); end
    tick(1);
    tests++; if (bfm_en !== 4'b1011 || state !== 2'd1) begin fails++; $display("FAIL rel_t9 got bfm_en=%b state=%0d exp 1011 1", bfm_en, state); end
    tick(1);
    tests++; if (bfm_en !== 4'b1011 || state !== 2'd2) begin fails++; $display("FAIL rel_t10 got bfm_en=%b state=%0d exp 1011 2", bfm_en, state); end
    stop();
    tick(ST);
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL rel_back_idle got=%0d exp=0", state); end
  endtask

  task automatic test_stop();
    write_cfg(1'b0, 4'b1111);
    start();
    tick(13);
    tests++; if (state !== 2'd2 || bfm_en !== 4'b1111) begin fails++; $display("FAIL stop_active got state=%0d bfm_en=%b exp 2 1111", state, bfm_en); end
    stop();
    tests++; if (state !== 2'd3 || bfm_en !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL stop_s1 got state=%0d bfm_en=%b busy=%b done=%b exp 3 0000 1 0", state, bfm_en, busy, done); end
    tick(3);
    tests++; if (state !== 2'd3 || done !== 1'b0) begin fails++; $display("FAIL stop_s4 got state=%0d done=%b exp 3 0", state, done); end
    tick(1);
    tests++; if (state !== 2'd0 || done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL stop_s5 got state=%0d done=%b busy=%b exp 0 1 0", state, done, busy); end
    tick(1);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL stop_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_stop_mid_release();
    start();
    tick(4);
    tests++; if (bfm_en !== 4'b0011 || state !== 2'd1) begin fails++; $display("FAIL mid_t5 got bfm_en=%b state=%0d exp 0011 1", bfm_en, state); end
    stop();
    tests++; if (state !== 2'd3 || bfm_en !== 4'b0000) begin fails++; $display("FAIL mid_s1 got state=%0d bfm_en=%b exp 3 0000", state, bfm_en); end
    cmd_start = 1'b1;
    tick(3);
    cmd_start = 1'b0;
    tests++; if (state !== 2'd3 || bfm_en !== 4'b0000) begin fails++; $display("FAIL mid_drain_cmd got state=%0d bfm_en=%b exp 3 0000", state, bfm_en); end
    tick(1);
    tests++; if (state !== 2'd0 || done !== 1'b1) begin fails++; $display("FAIL mid_s5 got state=%0d done=%b exp 0 1", state, done); end
  endtask

  task automatic test_counters();
    write_cfg(1'b0, 4'b0001);
    start();
    tick(1);
    tests++; if (state !== 2'd2 || bfm_en !== 4'b0001) begin fails++; $display("FAIL cnt_active got state=%0d bfm_en=%b exp 2 0001", state, bfm_en); end
    txn_in = 4'b0001;
    tick(10);
    tests++; if (txn_cnt[3:0] !== 4'd10) begin fails++; $display("FAIL cnt_ten got=%0d exp=10", txn_cnt[3:0]); end
    tick(10);
    tests++; if (txn_cnt[3:0] !== 4'd15) begin fails++; $display("FAIL cnt_sat got=%0d exp=15", txn_cnt[3:0]); end
    txn_in = 4'b0100;
    tick(3);
    tests++; if (txn_cnt[11:8] !== 4'd0 || txn_cnt[3:0] !== 4'd15) begin fails++; $display("FAIL cnt_disabled got ch2=%0d ch0=%0d exp 0 15", txn_cnt[11:8], txn_cnt[3:0]); end
    txn_in = 4'b0001;
    cmd_clr = 1'b1;
    tick(1);
    cmd_clr = 1'b0;
    tests++; if (txn_cnt !== 16'h0000) begin fails++; $display("FAIL cnt_clr got=%h exp=0000", txn_cnt); end
    tick(1);
    txn_in = 4'b0000;
    tests++; if (txn_cnt[3:0] !== 4'd1) begin fails++; $display("FAIL cnt_resume got=%0d exp=1", txn_cnt[3:0]); end
    write_cfg(1'b0, 4'b1111);
    tick(6);
    tests++; if (bfm_en !== 4'b0001 || state !== 2'd2) begin fails++; $display("FAIL mask_locked got bfm_en=%b state=%0d exp 0001 2", bfm_en, state); end
    stop();
    txn_in = 4'b0001;
    tick(2);
    txn_in = 4'b0000;
    tests++; if (txn_cnt[3:0] !== 4'd1) begin fails++; $display("FAIL cnt_drain_hold got=%0d exp=1", txn_cnt[3:0]); end
    tick(2);
    tests++; if (state !== 2'd0 || txn_cnt[3:0] !== 4'd1) begin fails++; $display("FAIL cnt_idle_hold got state=%0d cnt=%0d exp 0 1", state, txn_cnt[3:0]); end
  endtask

  task automatic test_start_ignored();
    write_cfg(1'b0, 4'b0000);
    start();
    tick(2);
    tests++; if (state !== 2'd0 || busy !== 1'b0 || bfm_en !== 4'b0000) begin fails++; $display("FAIL zero_mask got state=%0d busy=%b bfm_en=%b exp 0 0 0000", state, busy, bfm_en); end
    write_cfg(1'b0, 4'b0011);
    cmd_start = 1'b1;
    cmd_stop = 1'b1;
    tick(1);
    cmd_start = 1'b0;
    cmd_stop = 1'b0;
    tests++; if (state !== 2'd0 || bfm_en !== 4'b0000) begin fails++; $display("FAIL start_stop got state=%0d bfm_en=%b exp 0 0000", state, bfm_en); end
  endtask

  task automatic test_view_and_async_reset();
    logic [NA-1:0] exp_view;
`ifdef BENCH_BFM_CTRL_TXN_VIEW_EN
    exp_view = 4'b0101;
`else
    exp_view = 4'b0000;
`endif
    write_cfg(1'b1, 4'b0101);
    write_cfg(1'b0, 4'b0111);
    start();
    tick(9);
    tests++; if (state !== 2'd2 || bfm_en !== 4'b0111) begin fails++; $display("FAIL view_active got state=%0d bfm_en=%b exp 2 0111", state, bfm_en); end
    tests++; if (txn_view !== exp_view) begin fails++; $display("FAIL view_mask got=%b exp=%b", txn_view, exp_view); end
    txn_in = 4'b0010;
    tick(2);
    txn_in = 4'b0000;
    tests++; if (txn_cnt[7:4] !== 4'd2) begin fails++; $display("FAIL cnt_ch1 got=%0d exp=2", txn_cnt[7:4]); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (state !== 2'd0 || busy !== 1'b0 || bfm_en !== 4'b0000 || txn_view !== 4'b0000 || txn_cnt !== 16'h0000) begin fails++; $display("FAIL async_rst got state=%0d busy=%b bfm_en=%b view=%b cnt=%h exp all 0", state, busy, bfm_en, txn_view, txn_cnt); end
    tick(1);
    reset = 1'b1;
    write_cfg(1'b0, 4'b0111);
    start();
    tick(9);
    tests++; if (state !== 2'd2 || txn_view !== 4'b0000) begin fails++; $display("FAIL view_after_rst got state=%0d view=%b exp 2 0000", state, txn_view); end
    stop();
    tick(ST);
  endtask

  initial begin
    test_reset();
    test_release();
    test_stop();
    test_stop_mid_release();
    test_counters();
    test_start_ignored();
    test_view_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bench_bfm_ctrl.md
# bench_bfm_ctrl

Parametrised, multi-agent BFM activity controller in the bench HDL top. It replaces the single fixed agent-identifier scheme with per-channel control for NUM_AGENTS interfaces. It holds an agent enable mask and releases the enabled driver/monitor BFMs one at a time with a programmable stagger. It counts transactions per channel and drains cleanly on stop. An optional per-channel transaction-viewing mask is compiled in by macro.

## Interface
Parameters:
- NUM_AGENTS, 4, number of agent channels (1..16); channel index i maps to agent instance [i]
- CNT_W, 16, width of each per-channel transaction counter (4..32)
- STAGGER, 4, cycles between successive channel releases; also the drain length (1..255)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_wr  in  1  configuration write strobe
- cfg_sel  in  1  0 = enable mask, 1 = view mask
- cfg_wdata  in  NUM_AGENTS  mask write data
- cmd_start  in  1  start request, sampled per cycle
- cmd_stop  in  1  stop request, sampled per cycle
- cmd_clr  in  1  clear all counters
- txn_in  in  NUM_AGENTS  one-cycle transaction pulse per channel from the monitor BFM
- bfm_en  out  NUM_AGENTS  per-channel BFM enable
- txn_view  out  NUM_AGENTS  per-channel transaction-viewing enable
- txn_cnt  out  NUM_AGENTS*CNT_W  counters; channel i occupies bits [i*CNT_W +: CNT_W]
- state  out  2  0 IDLE, 1 RELEASE, 2 ACTIVE, 3 DRAIN
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse on DRAIN->IDLE

## Operation
- Reset values: state IDLE, enable mask 0, view mask 0, bfm_en 0, txn_view 0, all txn_cnt 0, busy 0, done 0.
- Enable mask writes (cfg_sel=0) are accepted only in IDLE and ignored elsewhere. View mask writes are accepted in any state.
- IDLE: bfm_en = 0.
  - cmd_start with a nonzero enable mask -> RELEASE.
  - cmd_start with a zero mask is ignored.
  - cmd_start and cmd_stop together: stop wins, start is ignored.
- RELEASE: enabled channels are asserted in ascending index order, one every STAGGER cycles. Asserted channels stay asserted.
  - After the highest enabled channel is asserted -> ACTIVE.
  - cmd_stop -> DRAIN.
- ACTIVE: bfm_en = enable mask; cmd_stop -> DRAIN; cmd_start is ignored.
- DRAIN: bfm_en = 0. A STAGGER-cycle countdown runs; at expiry -> IDLE with done=1 for one cycle. All commands are ignored during DRAIN.
- Counters:
  - txn_cnt[i] increments on txn_in[i] only while bfm_en[i]=1.
  - Counters saturate at 2^CNT_W-1; no wrap-around.
  - cmd_clr zeroes all counters in any state and wins over a same-cycle increment.
  - Counters hold their value through DRAIN and IDLE.
- Reset asserted mid-operation: everything returns to reset values immediately, asynchronously.

## Timing
- cfg write sampled at edge W takes effect at W+1.
- cmd_start sampled at edge T, with k enabled channels:
  - state = RELEASE and the lowest enabled bfm_en bit goes high at T+1.
  - The j-th enabled channel (j = 0..k-1) goes high at T+1+j*STAGGER.
  - state = ACTIVE at T+2+(k-1)*STAGGER.
- cmd_stop sampled at edge S (RELEASE or ACTIVE):
  - state = DRAIN and bfm_en = 0 at S+1.
  - state = IDLE and done = 1 at S+1+STAGGER.
- txn_in sampled at edge C appears in txn_cnt at C+1.
- busy is combinational from state.

## Configuration
- Macro: BENCH_BFM_CTRL_TXN_VIEW_EN.
- Defined: the view mask register exists and txn_view = view_mask & bfm_en (registered with bfm_en, same cycle).
- Undefined: no view mask register; writes with cfg_sel=1 are ignored; txn_view is tied to 0.

## Test plan
- Reset, then read all outputs -> every output 0, state 0.
- Defaults; write enable mask 4'b1011, then cmd_start at T -> bfm_en: 0001 at T+1, 0011 at T+5, 1011 at T+9; state=2 at T+10.
- ACTIVE with mask 1111; cmd_stop at S -> bfm_en=0 at S+1, state=3; done pulse and state=0 at S+5. Also cover stop issued mid-RELEASE.
- CNT_W=4, channel 0 enabled; 20 txn_in[0] pulses -> txn_cnt[0]=15 (saturated). Next, cmd_clr coincident with a pulse -> 0.
- Disabled channel 2 receives 3 pulses -> txn_cnt[2] stays 0. Enable mask write in ACTIVE -> mask unchanged. Start with mask 0 -> state stays 0.
- With macro: view mask 0101, enable mask 0111, ACTIVE -> txn_view=0101. Without macro -> txn_view=0.
